// File: rtl/usb_tx_ep_arbiter.sv
// Round-robin scheduler that drains endpoint IN FIFOs, one packet of up to MAX_PKT bytes at a time, into one USB transmit byte stream.
// Optional feature macro: USB_TX_EP0_PRIORITY_EN (endpoint 0 always wins arbitration when it requests).
module usb_tx_ep_arbiter #(
    parameter int NUM_EP  = 4,
    parameter int MAX_PKT = 64,
    localparam int EP_W   = $clog2(NUM_EP),
    localparam int CNT_W  = $clog2(MAX_PKT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EP-1:0]     ep_enable,
    input  logic [NUM_EP-1:0]     ep_empty,
    input  logic [8*NUM_EP-1:0]   ep_rddata,
    output logic [NUM_EP-1:0]     ep_rd_en,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_eop,
    output logic [EP_W-1:0]       tx_ep,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, SEND, EOP} state_t;

    state_t            state, state_n;
    logic [EP_W-1:0]   grant_n;
    logic [EP_W-1:0]   last_grant, last_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [NUM_EP-1:0] req;
    logic [EP_W-1:0]   arb_pick;
    logic              arb_found;
    logic [7:0]        rd_bytes [NUM_EP];

    for (genvar g = 0; g < NUM_EP; g++) begin : g_unpack
        assign rd_bytes[g] = ep_rddata[8*g +: 8];
    end

    assign req  = ep_enable & ~ep_empty;
    assign busy = (state != IDLE);

    // Search starts just after the last served endpoint, wrapping around.
    always_comb begin : arbitrate
        int idx;
        idx       = 0;
        arb_pick  = '0;
        arb_found = 1'b0;
`ifdef USB_TX_EP0_PRIORITY_EN
        if (req[0]) begin
            arb_pick  = '0;
            arb_found = 1'b1;
        end
`endif
        for (int off = 1; off <= NUM_EP; off++) begin
            idx = (int'(last_grant) + off) % NUM_EP;
`ifdef USB_TX_EP0_PRIORITY_EN
            if (!arb_found && idx != 0 && req[idx]) begin
`else
            if (!arb_found && req[idx]) begin
`endif
                arb_pick  = EP_W'(idx);
                arb_found = 1'b1;
            end
        end
    end

    // NOTE: every signal assigned here gets a default first so no path leaves one unassigned, which would infer a latch.
    always_comb begin : next_state
        state_n  = state;
        grant_n  = tx_ep;
        count_n  = count;
        last_n   = last_grant;
        tx_valid = 1'b0;
        tx_eop   = 1'b0;
        tx_data  = '0;
        ep_rd_en = '0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    grant_n = arb_pick;
                    count_n = '0;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                state_n = ep_empty[tx_ep] ? EOP : SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = rd_bytes[tx_ep];
                if (tx_ready) begin
                    // Pop in the handshake cycle; the FIFO's registered output is valid again after SETTLE.
                    ep_rd_en[tx_ep] = 1'b1;
                    count_n         = count + 1'b1;
                    state_n         = (count == CNT_W'(MAX_PKT - 1)) ? EOP : SETTLE;
                end
            end
            EOP: begin
                tx_eop  = 1'b1;
                state_n = IDLE;
`ifdef USB_TX_EP0_PRIORITY_EN
                if (tx_ep != '0) last_n = tx_ep;
`else
                last_n = tx_ep;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_ep      <= '0;
            count      <= '0;
            last_grant <= EP_W'(NUM_EP - 1);
        end else begin
            state      <= state_n;
            tx_ep      <= grant_n;
            count      <= count_n;
            last_grant <= last_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_ep_arbiter.sv
// Self-checking bench for usb_tx_ep_arbiter: FIFO models plus a packet-level round-robin reference model.
module tb_usb_tx_ep_arbiter;

    localparam int NUM_EP  = 4;
    localparam int MAX_PKT = 64;
    localparam int EP_W    = $clog2(NUM_EP);
    localparam int BUDGET  = 6000;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_EP-1:0]   ep_enable;
    logic [NUM_EP-1:0]   ep_empty;
    logic [8*NUM_EP-1:0] ep_rddata;
    logic [NUM_EP-1:0]   ep_rd_en;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx_eop;
    logic [EP_W-1:0]     tx_ep;
    logic                busy;

    always #5 clk = ~clk;

    usb_tx_ep_arbiter #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ep_enable (ep_enable),
        .ep_empty  (ep_empty),
        .ep_rddata (ep_rddata),
        .ep_rd_en  (ep_rd_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_eop    (tx_eop),
        .tx_ep     (tx_ep),
        .busy      (busy)
    );

    // Endpoint FIFOs: 512x8, registered read port, one write port driven by the stimulus.
    logic [7:0]        fmem [NUM_EP][512];
    int                f_rp [NUM_EP];
    int                f_wp [NUM_EP];
    int                f_cnt [NUM_EP];
    logic [7:0]        f_rd [NUM_EP];
    logic [NUM_EP-1:0] wr_en;
    logic [7:0]        wr_data;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_EP; i++) begin
            f_rd[i] <= fmem[i][f_rp[i]];
            if (ep_rd_en[i] && f_cnt[i] > 0) f_rp[i] <= (f_rp[i] + 1) % 512;
            if (wr_en[i]) begin
                fmem[i][f_wp[i]] <= wr_data;
                f_wp[i] <= (f_wp[i] + 1) % 512;
            end
            f_cnt[i] <= f_cnt[i] + (wr_en[i] ? 1 : 0) - ((ep_rd_en[i] && f_cnt[i] > 0) ? 1 : 0);
        end
    end

    always_comb begin
        ep_empty  = '0;
        ep_rddata = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            ep_empty[i]         = (f_cnt[i] == 0);
            ep_rddata[8*i +: 8] = f_rd[i];
        end
    end

    // Reference model: per-endpoint byte history plus the arbitration pointer.
    logic [7:0] rmem [NUM_EP][512];
    int         r_rp [NUM_EP];
    int         r_wp [NUM_EP];
    int         m_last;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rem(input int e);
        return r_wp[e] - r_rp[e];
    endfunction

    function automatic int model_pick(input logic [NUM_EP-1:0] mask);
`ifdef USB_TX_EP0_PRIORITY_EN
        if (mask[0] && rem(0) > 0) return 0;
`endif
        for (int off = 1; off <= NUM_EP; off++) begin
            int e;
            e = (m_last + off) % NUM_EP;
`ifdef USB_TX_EP0_PRIORITY_EN
            if (e == 0) continue;
`endif
            if (mask[e] && rem(e) > 0) return e;
        end
        return -1;
    endfunction

    function automatic bit model_pending(input logic [NUM_EP-1:0] mask);
        for (int e = 0; e < NUM_EP; e++)
            if (mask[e] && rem(e) > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Push n bytes into FIFO e; base < 0 gives random data, else base, base+1, ...
    task automatic load(input int e, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wr_en    = '0;
            wr_en[e] = 1'b1;
            wr_data  = (base < 0) ? 8'($urandom) : 8'(base + k);
            rmem[e][r_wp[e] % 512] = wr_data;
            r_wp[e]++;
        end
        @(negedge clk);
        wr_en = '0;
    endtask

    // Run until all enabled endpoints are drained; mode 0 ready high, 1 random ready, 2 five stalled SEND cycles.
    task automatic drain(input int mode);
        logic [7:0]      pkt [512];
        int              n, cyc, first_busy, last_eop, idle_cnt, sends_seen, exp_ep, exp_len;
        logic            prev_stall, prev_busy;
        logic [7:0]      prev_data;
        logic [EP_W-1:0] prev_ep, pkt_ep;
        n = 0; cyc = 0; first_busy = 0; last_eop = -1; idle_cnt = 0; sends_seen = 0;
        prev_stall = 1'b0; prev_busy = busy; prev_data = '0; prev_ep = '0; pkt_ep = '0;
        while (idle_cnt < 4 && cyc < BUDGET) begin
            @(negedge clk);
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 3) != 0);
                default: tx_ready = (sends_seen >= 5);
            endcase
            #1;
            cyc++;
            if (busy && !prev_busy) begin
                first_busy = cyc;
                if (last_eop >= 0) check("gap", cyc - last_eop, 2);
                else               check("grant_lat", cyc, 1);
            end
            if (tx_valid) begin
                sends_seen++;
                if (prev_stall) begin
                    check("hold_data", tx_data, prev_data);
                    check("hold_ep", tx_ep, prev_ep);
                end
                if (tx_ready) begin
                    check("rd_en", ep_rd_en, 32'(1) << tx_ep);
                    if (n == 0) pkt_ep = tx_ep;
                    else        check("ep_stable", tx_ep, pkt_ep);
                    pkt[n % 512] = tx_data;
                    n++;
                    prev_stall = 1'b0;
                end else begin
                    check("rd_en_stall", ep_rd_en, 0);
                    prev_stall = 1'b1;
                    prev_data  = tx_data;
                    prev_ep    = tx_ep;
                end
            end else begin
                if (prev_stall) check("valid_drop", 0, 1);
                prev_stall = 1'b0;
                check("rd_en_idle", ep_rd_en, 0);
            end
            if (tx_eop) begin
                check("eop_valid", tx_valid, 0);
                exp_ep = model_pick(ep_enable);
                if (exp_ep < 0) begin
                    check("spurious_pkt", tx_ep, 255);
                end else begin
                    exp_len = (rem(exp_ep) < MAX_PKT) ? rem(exp_ep) : MAX_PKT;
                    check("pkt_ep", tx_ep, exp_ep);
                    if (n > 0) check("eop_ep_stable", tx_ep, pkt_ep);
                    check("pkt_len", n, exp_len);
                    for (int k = 0; k < n && k < exp_len; k++)
                        check("pkt_byte", pkt[k], rmem[exp_ep][(r_rp[exp_ep] + k) % 512]);
                    if (mode == 0)
                        check("pkt_cycles", cyc - first_busy, 2 * exp_len + ((exp_len < MAX_PKT) ? 1 : 0));
                    r_rp[exp_ep] += exp_len;
`ifdef USB_TX_EP0_PRIORITY_EN
                    if (exp_ep != 0) m_last = exp_ep;
`else
                    m_last = exp_ep;
`endif
                end
                n = 0;
                last_eop = cyc;
            end
            if (!busy && !model_pending(ep_enable)) idle_cnt++;
            else idle_cnt = 0;
            prev_busy = busy;
        end
        check("drain_timeout", (cyc < BUDGET) ? 1 : 0, 1);
        check("drain_idle", busy, 0);
    endtask

    task automatic arm(input logic [NUM_EP-1:0] mask);
        @(negedge clk);
        ep_enable = mask;
    endtask

    initial begin
        int  hs;
        bit  hit;
        rst = 1'b1; ep_enable = '0; tx_ready = 1'b0; wr_en = '0; wr_data = '0;
        m_last = NUM_EP - 1;
        for (int e = 0; e < NUM_EP; e++) begin r_rp[e] = 0; r_wp[e] = 0; end
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_eop", tx_eop, 0);
        check("rst_rd_en", ep_rd_en, 0);
        check("rst_data", tx_data, 0);
        check("rst_ep", tx_ep, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Round robin from reset: 0, 2, 3, then 0, 3.
        load(0, 1, -1); load(2, 1, -1); load(3, 1, -1);
        arm('1); drain(0);
        arm('0); load(0, 1, -1); load(3, 1, -1);
        arm('1); drain(0);

        // Short packet of A1, A2, A3 on EP1.
        arm('0); load(1, 3, 8'hA1);
        arm('1); drain(0);

        // 70 bytes on EP0 split into 64 + 6.
        arm('0); load(0, 70, -1);
        arm('1); drain(0);

        // Backpressure on a 2-byte EP1 packet.
        arm('0); load(1, 2, -1);
        arm('1); drain(2);

`ifdef USB_TX_EP0_PRIORITY_EN
        arm('0); load(2, 4, -1); load(0, 1, -1);
        arm('1); drain(0);
`endif

        // Reset after the 2nd byte of a 10-byte EP0 packet; EP3 waits disabled.
        arm('0); load(0, 10, -1); load(3, 2, -1);
        arm(4'b0001);
        hs = 0; hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            #1;
            if (tx_valid && hs == 2) hit = 1'b1;
            else if (tx_valid && tx_ready) hs++;
        end
        check("rst_setup", hit, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_rd_en", ep_rd_en, 0);
        check("mid_rst_busy", busy, 0);
        r_rp[0] += 2;
        m_last = NUM_EP - 1;
        @(negedge clk);
        ep_enable = '1;
        rst = 1'b0;
        drain(0);

        // Randomized phases with random enable masks and ready patterns.
        for (int it = 0; it < 12; it++) begin
            arm('0);
            for (int e = 0; e < NUM_EP; e++) begin
                int n;
                n = $urandom_range(0, 40);
                if (rem(e) + n <= 150) load(e, n, -1);
            end
            arm(NUM_EP'($urandom_range(1, (1 << NUM_EP) - 1)));
            drain(($urandom_range(0, 2) == 0) ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
